// File: rtl/lcd_text_composer.sv
// Purpose : formats a 16-bit value as two LCD text lines ("VAL=" decimal, "HEX=0x" hex)
//           and hands the buffer to an LCD text sender, waiting for its completion.
// Latency : sendText pulses 18 cycles after the accept edge; done/timeout returns to IDLE.
// Backpr. : value_ready only in IDLE; offers made while busy are dropped, not queued.
// Ports   : CLK/RST (sync, active-high); value_valid/value/value_ready input handshake;
//           sendingDone level from sender; sendText one-cycle request; text character
//           buffer (char 1 in the top byte); busy; timeout_err (sticky until next accept).
module lcd_text_composer #(
  parameter int TEXT_LENGTH    = 34,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     value_valid,
  input  logic [15:0]              value,
  output logic                     value_ready,
  input  logic                     sendingDone,
  output logic                     sendText,
  output logic [8*TEXT_LENGTH:1]   text,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CONVERT, BUILD, SEND, WAIT} state_t;

  state_t                  state_q;
  logic [15:0]             val_q;
  logic [15:0]             shf_q;
  logic [19:0]             bcd_q;
  logic [3:0]              bit_q;
  logic [CW-1:0]           cnt_q;
  logic                    done_prev_q;
  logic                    send_q;
  logic                    terr_q;
  logic [8*TEXT_LENGTH:1]  text_q;

  logic [19:0]             bcd_adj;
  logic                    accept;
  logic                    done_rise;

  // Character buffer layout. With filled=0 this is the blank template: only the
  // two line-feed characters, everything else a space.
  function automatic logic [8*TEXT_LENGTH:1] layout(input logic        filled,
                                                    input logic [19:0] bcd,
                                                    input logic [15:0] v);
    logic [7:0]  ch;
    logic [19:0] sh;
    logic [15:0] hv;
    layout = '0;
    for (int i = 1; i <= TEXT_LENGTH; i++) begin
      ch = 8'h20;
      sh = bcd >> (4 * (10 - i));
      hv = v >> (4 * (28 - i));
      if (i == 1 || i == 18) begin
        ch = 8'h0A;
      end else if (filled) begin
        case (i)
          2:  ch = 8'h56;                  // V
          3:  ch = 8'h41;                  // A
          4:  ch = 8'h4C;                  // L
          5:  ch = 8'h3D;                  // =
          // A digit is shown once it, or any more significant digit, is non-zero;
          // the units digit (char 10) is always shown.
          6, 7, 8, 9, 10:
            ch = (i == 10 || sh != 20'd0) ? (8'h30 + {4'h0, sh[3:0]}) : 8'h20;
          19: ch = 8'h48;                  // H
          20: ch = 8'h45;                  // E
          21: ch = 8'h58;                  // X
          22: ch = 8'h3D;                  // =
          23: ch = 8'h30;                  // 0
          24: ch = 8'h78;                  // x
          25, 26, 27, 28:
            ch = (hv[3:0] < 4'd10) ? (8'h30 + {4'h0, hv[3:0]}) : (8'h37 + {4'h0, hv[3:0]});
          default: ch = 8'h20;
        endcase
      end
      layout[(TEXT_LENGTH - i) * 8 + 1 +: 8] = ch;
    end
  endfunction

  // Double-dabble correction applied before each left shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < 5; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  assign value_ready = (state_q == IDLE) && !RST;
  assign busy        = (state_q != IDLE) && !RST;
  assign sendText    = send_q && !RST;
  assign timeout_err = terr_q && !RST;
  assign text        = text_q;
  assign accept      = value_valid && value_ready;
  // Only a fresh rising edge observed while waiting counts; a level already high
  // on WAIT entry has done_prev_q=1 and is ignored.
  assign done_rise   = (state_q == WAIT) && sendingDone && !done_prev_q;

  always_ff @(posedge CLK) begin
    done_prev_q <= sendingDone;
    if (RST) begin
      state_q <= IDLE;
      val_q   <= '0;
      shf_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      send_q  <= 1'b0;
      terr_q  <= 1'b0;
      text_q  <= layout(1'b0, 20'd0, 16'd0);
    end else begin
      send_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            val_q   <= value;
            shf_q   <= value;
            bcd_q   <= '0;
            bit_q   <= '0;
            terr_q  <= 1'b0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_q, shf_q} <= {bcd_adj, shf_q} << 1;
          bit_q          <= bit_q + 4'd1;
          if (bit_q == 4'd15) state_q <= BUILD;
        end
        BUILD: begin
          text_q  <= layout(1'b1, bcd_q, val_q);
          state_q <= SEND;
        end
        SEND: begin
          send_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (done_rise) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            terr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_composer.sv
module tb_lcd_text_composer;
  localparam int TL = 34;
  localparam int TO = 100;

  logic          CLK = 1'b0;
  logic          RST;
  logic          value_valid;
  logic [15:0]   value;
  logic          value_ready;
  logic          sendingDone;
  logic          sendText;
  logic [8*TL:1] text;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;

  typedef struct {
    logic [8*TL:1] txt;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  lcd_text_composer #(.TEXT_LENGTH(TL), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .value_valid(value_valid), .value(value),
    .value_ready(value_ready), .sendingDone(sendingDone), .sendText(sendText),
    .text(text), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference text: built from the layout rules with plain decimal/hex arithmetic.
  function automatic logic [8*TL:1] exp_text(input bit filled, input int v);
    logic [8*TL:1] t;
    string lab1 = "VAL=";
    string lab2 = "HEX=0x";
    string hx   = "0123456789ABCDEF";
    int p10;
    for (int i = 1; i <= TL; i++) t[(TL-i)*8+1 +: 8] = 8'h20;
    t[(TL-1)*8+1 +: 8]  = 8'h0A;
    t[(TL-18)*8+1 +: 8] = 8'h0A;
    if (filled) begin
      for (int k = 0; k < 4; k++) t[(TL-(2+k))*8+1 +: 8] = lab1[k];
      p10 = 10000;
      for (int k = 0; k < 5; k++) begin
        if (v >= p10 || p10 == 1) t[(TL-(6+k))*8+1 +: 8] = 8'h30 + 8'((v / p10) % 10);
        p10 = p10 / 10;
      end
      for (int k = 0; k < 6; k++) t[(TL-(19+k))*8+1 +: 8] = lab2[k];
      for (int k = 0; k < 4; k++) t[(TL-(25+k))*8+1 +: 8] = hx[(v >> (4*(3-k))) & 15];
    end
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_text(input string nm, input logic [8*TL:1] act, input logic [8*TL:1] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every sendText pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b0 && sendText === 1'b1) begin
      exp_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_sendText", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("send_cycle", cyc, e.due);
        chk_text("send_text", text, e.txt);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (value_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", value_ready, 1);
  endtask

  // Offer v at a negedge while ready; the following posedge is the accept edge.
  task automatic offer(input int v);
    value_valid = 1'b1;
    value       = 16'(v);
    exp_q.push_back('{txt: exp_text(1, v), due: cyc + 19});
    tick();
    value_valid = 1'b0;
    value       = 16'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", value_ready, 0);
    chk("terr_cleared_on_accept", timeout_err, 0);
  endtask

  task automatic wait_send(output int sc);
    int n = 0;
    while (sendText !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("send_seen", sendText, 1);
    sc = cyc;
  endtask

  task automatic run_txn(input int v, input bit hold_valid);
    int sc;
    int d;
    wait_ready();
    offer(v);
    wait_send(sc);
    d = $urandom_range(0, 15);
    if (hold_valid) begin
      value_valid = 1'b1;
      value       = 16'(~v);
    end
    repeat (d) tick();
    chk("busy_in_wait", busy, 1);
    sendingDone = 1'b1;
    tick();
    value_valid = 1'b0;
    chk("ready_after_done", value_ready, 1);
    chk("busy_after_done", busy, 0);
    chk("terr_after_done", timeout_err, 0);
    chk_text("text_held", text, exp_text(1, v));
    sendingDone = 1'b0;
  endtask

  task automatic reset_and_check(input string nm);
    int p;
    RST = 1'b1;
    tick();
    chk({nm, "_ready_in_rst"}, value_ready, 0);
    chk({nm, "_busy_in_rst"}, busy, 0);
    chk({nm, "_send_in_rst"}, sendText, 0);
    chk({nm, "_terr_in_rst"}, timeout_err, 0);
    tick();
    RST = 1'b0;
    exp_q.delete();
    p = pulses;
    tick();
    chk({nm, "_ready_after_rst"}, value_ready, 1);
    chk({nm, "_busy_after_rst"}, busy, 0);
    chk_text({nm, "_blank_text"}, text, exp_text(0, 0));
    repeat (30) tick();
    chk({nm, "_no_pulse_after_rst"}, pulses, p);
  endtask

  initial begin
    int sc;
    int n;
    int v;
    RST = 1'b1; value_valid = 1'b0; value = '0; sendingDone = 1'b0;

    // Reset behaviour.
    tick();
    reset_and_check("init");

    // Directed values.
    run_txn(0, 1'b0);
    run_txn(65535, 1'b0);
    run_txn(1234, 1'b1);
    run_txn(10000, 1'b0);
    run_txn(9, 1'b1);

    // Randomised values, biased towards short numbers for digit blanking.
    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 65535));
      run_txn(v, 1'(($urandom_range(0, 1))));
    end

    // sendingDone already high on WAIT entry must not count as completion.
    wait_ready();
    offer(4321);
    sendingDone = 1'b1;
    wait_send(sc);
    value_valid = 1'b1;
    value       = 16'h1111;
    tick(); tick();
    chk("held_done_busy", busy, 1);
    sendingDone = 1'b0;
    repeat (5) tick();
    chk("low_done_busy", busy, 1);
    sendingDone = 1'b1;
    tick();
    value_valid = 1'b0;
    chk("edge_done_ready", value_ready, 1);
    chk("edge_done_terr", timeout_err, 0);
    sendingDone = 1'b0;

    // Timeout: IDLE exactly TO cycles after WAIT entry, sticky error.
    wait_ready();
    offer(777);
    wait_send(sc);
    n = 0;
    while (value_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycle", cyc, sc + TO);
    chk("timeout_err_set", timeout_err, 1);
    tick();
    chk("timeout_err_sticky", timeout_err, 1);
    run_txn(42, 1'b0);

    // Completion on the same edge as the timeout wins.
    wait_ready();
    offer(31337);
    wait_send(sc);
    while (cyc < sc + TO - 1) tick();
    sendingDone = 1'b1;
    tick();
    chk("coincide_cycle", cyc, sc + TO);
    chk("coincide_ready", value_ready, 1);
    chk("coincide_terr", timeout_err, 0);
    sendingDone = 1'b0;

    // Reset during CONVERT (cycle 8) aborts without a request.
    wait_ready();
    offer(5555);
    repeat (7) tick();
    chk("abort_conv_busy", busy, 1);
    reset_and_check("abort_conv");

    // Reset during WAIT.
    wait_ready();
    offer(60000);
    wait_send(sc);
    repeat (3) tick();
    reset_and_check("abort_wait");

    run_txn(100, 1'b0);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_text_composer.md
LCD_TEXT_COMPOSER -- requirements
Module: lcd_text_composer

Interface
REQ-001 Parameter: TEXT_LENGTH, default 34, text buffer length in characters.
REQ-002 Parameter: TIMEOUT_CYCLES, default 5000000, maximum cycles to wait for display completion (100 ms at 50 MHz).
REQ-003 Port: CLK  in  1  system clock; all logic on rising edge.
REQ-004 Port: RST  in  1  reset, synchronous, active-high.
REQ-005 Port: value_valid  in  1  upstream offers value.
REQ-006 Port: value  in  16  unsigned binary value to display.
REQ-007 Port: value_ready  out  1  block accepts value this cycle.
REQ-008 Port: sendingDone  in  1  level from the LCD text sender; its 0->1 transition marks completion of a transfer.
REQ-009 Port: sendText  out  1  one-cycle request to the LCD text sender.
REQ-010 Port: text  out  8*TEXT_LENGTH, indexed [8*TEXT_LENGTH:1]  character buffer; char i (1-based) occupies text[(TEXT_LENGTH-i)*8+1 +: 8].
REQ-011 Port: busy  out  1  high in any state other than IDLE.
REQ-012 Port: timeout_err  out  1  sticky flag; last transfer timed out.

Function
REQ-013 FSM states SHALL be IDLE, CONVERT, BUILD, SEND and WAIT.
REQ-014 value_ready SHALL equal (state==IDLE); accept = value_valid & value_ready; on accept, capture value, clear timeout_err, enter CONVERT.
REQ-015 value_valid outside IDLE SHALL be ignored; no queuing.
REQ-016 CONVERT: sequential shift-add-3 binary-to-BCD, one shift per cycle, exactly 16 cycles, 5 BCD digits (20-bit).
REQ-017 BUILD: one cycle; load text; next state SEND.
REQ-018 Text layout: char 1 = 0x0A; chars 2-17 = line 1; char 18 = 0x0A; chars 19-34 = line 2.
REQ-019 Line 1: "VAL=" + 5 decimal digits right-aligned, leading zeros replaced by 0x20, units digit always shown + 7 spaces.
REQ-020 Line 2: "HEX=0x" + 4 hex digits, uppercase A-F, zero-padded + 6 spaces.
REQ-021 SEND: sendText=1 for exactly one cycle, 18 cycles after the accept edge (16 CONVERT + 1 BUILD + 1); next state WAIT.
REQ-022 text SHALL be stable from BUILD exit until the next BUILD.
REQ-023 sendingDone SHALL be registered once (prev sample); completion = sample 1 with prev 0, detected only in WAIT.
REQ-024 A sendingDone level that is already high on entry to WAIT SHALL NOT count as completion.
REQ-025 WAIT: on completion, go to IDLE; value_ready=1 on the next cycle.
REQ-026 WAIT: counter starts at 0 on entry; when it reaches TIMEOUT_CYCLES-1 without completion, set timeout_err=1 and go to IDLE.
REQ-027 If completion and timeout coincide, completion wins; timeout_err stays 0.
REQ-028 Counter width SHALL be ceil(log2(TIMEOUT_CYCLES)) and SHALL NOT wrap.

Reset
REQ-029 While RST=1 and on the following cycle: state=IDLE, sendText=0, busy=0, timeout_err=0, value_ready=0 during RST and 1 after.
REQ-030 RST forces text to the blank template: chars 1 and 18 = 0x0A; all others 0x20.
REQ-031 RST in any state, including mid-CONVERT and WAIT, SHALL abort with no sendText pulse afterwards; captured value and BCD are discarded.

Verification
REQ-032 value=0 accepted -> sendText at accept+18; line1 "VAL=    0       "; line2 "HEX=0x0000      ".
REQ-033 value=65535 -> "VAL=65535       " and "HEX=0xFFFF      "; value=1234 -> "VAL= 1234       " and "HEX=0x04D2      ".
REQ-034 sendingDone held 1 entering WAIT, then 0 for 5 cycles, then 1 -> IDLE only after the 0->1 edge; value_valid held during WAIT -> not accepted.
REQ-035 TIMEOUT_CYCLES=100, sendingDone held 0 -> timeout_err=1 and IDLE exactly 100 cycles after WAIT entry; next accept clears timeout_err.
REQ-036 RST at CONVERT cycle 8 -> no sendText pulse, text equals the blank template, value_ready=1 after release.
REQ-037 Completion edge on the same cycle as timeout -> IDLE with timeout_err=0.
